// File: rtl/udma_uart_pkg.sv
// Shared definitions for the uDMA UART receiver: FSM state encoding and
// data-width field encoding.
package udma_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_rx_state_e;

    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    // Index of the final data bit for a given width code (4..7).
    function automatic logic [2:0] last_data_idx(input logic [1:0] bits);
        return 3'd4 + {1'b0, bits};
    endfunction

endpackage

// File: rtl/udma_uart_sync.sv
// Multi-flop synchroniser for a single asynchronous line; all flops reset
// to 1 so an idle-high line never looks like a falling edge after reset.
module udma_uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], din};
        end
    end

    assign dout = ff_q[STAGES-1];

endmodule

// File: rtl/udma_uart_rx.sv
// UART receiver: oversampled start detection, 5-8 data bits LSB-first,
// optional even parity, one or two stop bits, single-entry output buffer.
module udma_uart_rx
    import udma_uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_parity_en_i,
    input  logic        cfg_stop_bits_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        err_parity_o,
    output logic        err_overflow_o,
    output logic        busy_o
);

    uart_rx_state_e state_q, state_d;

    logic        rx_s;
    logic        rx_prev_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        err_par_q;
    logic        err_ovf_q;

    logic        mid;
    logic        wrap;
    logic        fall;
    logic        last_data;
    logic        last_stop;
    logic        state_chg;
    logic        done;
    logic [7:0]  frame_byte;

    udma_uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (rx_i),
        .dout (rx_s)
    );

    assign mid       = (cnt_q == (cfg_div_i >> 1));
    // >= rather than == so a mid-frame divider change cannot strand the counter.
    assign wrap      = (cnt_q >= cfg_div_i);
    assign fall      = rx_prev_q & ~rx_s;
    assign last_data = (bit_cnt_q == last_data_idx(cfg_bits_i));
    assign last_stop = (bit_cnt_q[0] == cfg_stop_bits_i);
    assign state_chg = (state_d != state_q);

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fall) state_d = StStart;
                end
                StStart: begin
                    if (mid && rx_s) begin
                        state_d = StIdle;
                    end else if (wrap) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (wrap && last_data) begin
                        state_d = cfg_parity_en_i ? StParity : StStop;
                    end
                end
                StParity: begin
                    if (wrap) state_d = StStop;
                end
                StStop: begin
                    if (mid && last_stop) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy_o = (state_q != StIdle);
        done   = cfg_en_i && (state_q == StStop) && mid && last_stop;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            rx_prev_q <= rx_s;
            if ((state_q == StIdle) || state_chg || wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (state_chg) begin
                bit_cnt_q <= '0;
            end else if (wrap && ((state_q == StData) || (state_q == StStop))) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    // Data bits enter at the MSB; the final width is realigned on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (state_q == StIdle) begin
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (mid && (state_q == StData)) begin
            shift_q <= {rx_s, shift_q[7:1]};
            par_q   <= par_q ^ rx_s;
        end else if (mid && (state_q == StParity)) begin
            par_q   <= par_q ^ rx_s;
        end
    end

    always_comb begin
        frame_byte = shift_q;
        unique case (cfg_bits_i)
            BITS_5:  frame_byte = {3'b000, shift_q[7:3]};
            BITS_6:  frame_byte = {2'b00, shift_q[7:2]};
            BITS_7:  frame_byte = {1'b0, shift_q[7:1]};
            BITS_8:  frame_byte = shift_q;
            default: frame_byte = shift_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            err_par_q <= 1'b0;
            err_ovf_q <= 1'b0;
            if (done) begin
                err_par_q <= cfg_parity_en_i & par_q;
                if (valid_q && !rx_ready_i) begin
                    err_ovf_q <= 1'b1;
                end else begin
                    data_q  <= frame_byte;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && rx_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign err_parity_o   = err_par_q;
    assign err_overflow_o = err_ovf_q;

endmodule

// File: doc/udma_uart_rx.md
UDMA_UART_RX -- requirements
Module: udma_uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops synchronising rx_i (minimum 2).
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx_i  input  1  serial line, asynchronous to clk_i, idle high.
REQ-005 SHALL have port cfg_en_i  input  1  receiver enable.
REQ-006 SHALL have port cfg_div_i  input  16  bit period minus one, in clk_i cycles.
REQ-007 SHALL have port cfg_bits_i  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 SHALL have port cfg_parity_en_i  input  1  even-parity bit present.
REQ-009 SHALL have port cfg_stop_bits_i  input  1  0=one stop bit, 1=two stop bits.
REQ-010 SHALL have port rx_data_o  output  8  received byte, LSB-aligned, upper unused bits zero.
REQ-011 SHALL have port rx_valid_o  output  1  rx_data_o holds an undelivered byte.
REQ-012 SHALL have port rx_ready_i  input  1  consumer accepts the byte.
REQ-013 SHALL have port err_parity_o  output  1  one-cycle pulse on a parity mismatch.
REQ-014 SHALL have port err_overflow_o  output  1  one-cycle pulse when a byte is dropped.
REQ-015 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass rx_i through SYNC_STAGES flops, each reset to 1, before any use.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL use a 16-bit bit counter that counts 0..cfg_div_i, so one bit period is cfg_div_i+1 cycles.
REQ-019 SHALL take the mid-bit sample at counter value cfg_div_i>>1.
REQ-020 IDLE: SHALL move to START on a synchronised 1->0 edge while cfg_en_i=1, with the counter cleared.
REQ-021 START: a mid-bit sample of 1 SHALL return the FSM to IDLE (false start, no outputs); a sample of 0 SHALL move to DATA at counter wrap.
REQ-022 DATA: SHALL shift bits in LSB-first, sampling 5+cfg_bits_i bits.
REQ-023 After the last data bit SHALL go to PARITY if cfg_parity_en_i=1, else to STOP.
REQ-024 PARITY: SHALL flag a mismatch when the XOR of the data bits and the parity bit equals 1.
REQ-025 STOP: SHALL sample 1+cfg_stop_bits_i stop bits.
REQ-026 At the mid-sample of the last stop bit SHALL complete the frame and go to IDLE, without waiting for the bit to end.
REQ-027 A stop bit sampled as 0 SHALL NOT be reported; the frame SHALL still complete.
REQ-028 On completion SHALL load the byte and assert rx_valid_o on the next cycle.
REQ-029 On completion SHALL pulse err_parity_o on that same cycle if a mismatch was flagged; the byte SHALL still be delivered.
REQ-030 rx_valid_o SHALL stay high until a cycle with rx_valid_o=1 and rx_ready_i=1, then SHALL drop on the next cycle.
REQ-031 Overflow: if a frame completes while rx_valid_o=1 and rx_ready_i=0, SHALL drop the new byte, keep the old one and pulse err_overflow_o.
REQ-032 A frame completing in the same cycle as an accepting handshake SHALL load the new byte with rx_valid_o held high, and SHALL NOT report overflow.
REQ-033 cfg_en_i=0 in any state SHALL force IDLE on the next cycle and abort the frame: no valid, no error pulses, held byte retained.
REQ-034 Configuration inputs SHALL be stable during a frame; changes mid-frame give undefined frame contents but SHALL NOT lock up the FSM.
REQ-035 cfg_div_i=0 SHALL give one-cycle bits with the sample at counter 0.

Reset
REQ-036 rst_i SHALL asynchronously force IDLE, with counters and shift register 0 and synchroniser flops 1.
REQ-037 Output reset values SHALL be: rx_data_o=0, rx_valid_o=0, err_parity_o=0, err_overflow_o=0, busy_o=0.
REQ-038 Reset mid-frame SHALL discard the frame, and no pulse SHALL follow the reset release.

Structure
REQ-039 The FSM state enum and the cfg_bits_i encoding constants SHALL live in shared package udma_uart_pkg.
REQ-040 The synchroniser SHALL be sub-module udma_uart_sync (parameter STAGES, reset value 1); everything else SHALL be flat.

Verification
REQ-041 div=3, 8N1, rx_ready_i=1, byte 0xA5 sent -> rx_data_o=0xA5, rx_valid_o high one cycle, no error pulses.
REQ-042 div=3, 8E1, 0x07 sent with parity bit 0 -> rx_data_o=0x07 and one err_parity_o pulse in the completion cycle.
REQ-043 div=7, 5N2, 0x1F then 0x0A sent, rx_ready_i=0 -> rx_data_o stays 0x1F, one err_overflow_o pulse; set rx_ready_i=1 -> rx_valid_o drops.
REQ-044 div=15, rx_i low for 3 cycles -> FSM returns to IDLE, rx_valid_o stays 0, busy_o high then low.
REQ-045 cfg_en_i dropped during DATA -> IDLE next cycle, no valid; the next frame 0x3C is received correctly.
REQ-046 rst_i asserted mid-DATA -> all outputs 0 immediately; the next frame 0x81 is received correctly.
